// File: rtl/magic_ctrl_if.sv
// cpu_bus: Z80-style CPU bus as seen by the magic controller.
//   mreq, ioreq : memory / I/O request qualifiers (active-high)
//   m1          : opcode fetch cycle marker
//   rd, wr      : read / write strobes
//   a[15:0]     : address bus
//   d[7:0]      : data bus value presented by the CPU or memory
interface cpu_bus;
    logic        mreq;
    logic        ioreq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;

    modport ctrl (input mreq, ioreq, m1, rd, wr, a, d);
endinterface

// File: rtl/magic_ctrl.sv
// magic_ctrl: NMI / magic-ROM mapping controller with a byte-wide config
// register file reachable through the magic config I/O port.
//
// Ports:
//   clk28        system clock
//   rst          asynchronous active-high reset
//   bus          CPU bus (cpu_bus.ctrl): mreq, ioreq, m1, rd, wr, a, d
//   n_int        current INT level
//   n_int_next   INT level for the next cycle (frame edge = 1 -> 0)
//   nmi_src      level NMI trigger requests, one bit per source
//   n_nmi        NMI to the CPU, active-low
//   magic_mode   magic session active
//   magic_map    magic ROM/RAM mapped into the CPU space
//   cfg          flat config register contents, byte 0 reads as zero
//   cfg_wr_stb   one-cycle pulse per index on the first write cycle to it
//   d_out        config port read data
//   d_out_active d_out should drive the CPU data bus
module magic_ctrl #(
    parameter int                    NUM_SRC        = 4,
    parameter int                    NUM_REGS       = 16,
    parameter logic [NUM_REGS*8-1:0] CFG_RESET      = '0,
    parameter logic [15:0]           ENTRY_ADDR     = 16'h0066,
    parameter logic [15:0]           EXIT_ADDR      = 16'hF000,
    parameter logic [15:0]           REMAP_ADDR     = 16'hF008,
    parameter logic [7:0]            SIGNATURE      = 8'hEB,
    parameter logic [7:0]            CONFIG_PORT    = 8'hFF,
    parameter bit                    MAGIC_ON_START = 1'b1,
    parameter int                    TIMEOUT        = 4095
) (
    input  logic                    clk28,
    input  logic                    rst,
    cpu_bus.ctrl                    bus,
    input  logic                    n_int,
    input  logic                    n_int_next,
    input  logic [NUM_SRC-1:0]      nmi_src,
    output logic                    n_nmi,
    output logic                    magic_mode,
    output logic                    magic_map,
    output logic [NUM_REGS*8-1:0]   cfg,
    output logic [NUM_REGS-1:0]     cfg_wr_stb,
    output logic [7:0]              d_out,
    output logic                    d_out_active
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NMI_PEND,
        S_CHECK,
        S_ACTIVE,
        S_UNMAP_WAIT,
        S_REMAP_WAIT
    } state_t;

    state_t               state, state_n;
    logic                 n_nmi_n, mode_n, map_n;
    logic [NUM_SRC-1:0]   cause, cause_n;
    logic                 to_flag, to_flag_n;
    logic [TW-1:0]        timer, timer_n;
    logic                 chk_seen, chk_seen_n;
    logic                 chk_match, chk_match_n;
    logic                 exit_req, exit_req_n;
    logic                 timeout_hit, drop_cause;

    // Byte 0 of the register file is the status/cause register and has no storage here.
    logic [NUM_REGS*8-1:8] cfg_q;
    logic                  wr_prev;
    logic [NUM_REGS-1:0]   stb_hit;
    logic [7:0]            status;

    logic       fetch, fetch_rd, mem_rd, frame_edge;
    logic       cfg_cs, cfg_wr, cfg_rd, idx_ok, clr_stat;
    logic [7:0] idx;

    assign fetch      = bus.m1 && bus.mreq;
    assign fetch_rd   = fetch && bus.rd;
    assign mem_rd     = bus.mreq && bus.rd;
    assign frame_edge = n_int && !n_int_next;

    assign idx      = bus.a[15:8];
    assign idx_ok   = ({1'b0, idx} < 9'(NUM_REGS));
    assign cfg_cs   = magic_map && bus.ioreq && (bus.a[7:0] == CONFIG_PORT);
    assign cfg_wr   = cfg_cs && bus.wr;
    assign cfg_rd   = cfg_cs && bus.rd && idx_ok;
    assign clr_stat = cfg_wr && (idx == 8'd0);

    assign cfg = {cfg_q, 8'h00};

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        n_nmi_n     = n_nmi;
        mode_n      = magic_mode;
        map_n       = magic_map;
        timer_n     = timer;
        chk_seen_n  = chk_seen;
        chk_match_n = chk_match;
        exit_req_n  = exit_req;
        timeout_hit = 1'b0;
        drop_cause  = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame_edge && (|nmi_src)) begin
                    state_n = S_NMI_PEND;
                    n_nmi_n = 1'b0;
                    mode_n  = 1'b1;
                    timer_n = '0;
                end
            end
            S_NMI_PEND: begin
                // The vector fetch wins over a timeout landing on the same cycle.
                if (fetch && (bus.a == ENTRY_ADDR)) begin
                    n_nmi_n = 1'b1;
                    map_n   = 1'b1;
                    state_n = S_CHECK;
                end else if ((TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1))) begin
                    n_nmi_n     = 1'b1;
                    mode_n      = 1'b0;
                    timeout_hit = 1'b1;
                    state_n     = S_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_CHECK: begin
                // Capture on the first opcode read, decide once that fetch has ended.
                if (!chk_seen) begin
                    if (fetch_rd) begin
                        chk_seen_n  = 1'b1;
                        chk_match_n = (bus.d == SIGNATURE);
                    end
                end else if (!fetch_rd) begin
                    chk_seen_n = 1'b0;
                    if (chk_match) begin
                        state_n = S_ACTIVE;
                    end else begin
                        state_n    = S_IDLE;
                        map_n      = 1'b0;
                        mode_n     = 1'b0;
                        drop_cause = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (mem_rd && (bus.a == EXIT_ADDR)) begin
                    mode_n     = 1'b0;
                    exit_req_n = 1'b1;
                    state_n    = S_UNMAP_WAIT;
                end else if (mem_rd && (bus.a == REMAP_ADDR)) begin
                    exit_req_n = 1'b0;
                    state_n    = S_UNMAP_WAIT;
                end
            end
            S_UNMAP_WAIT: begin
                // Keep the ROM mapped until the exit/remap read cycle has completed.
                if (!bus.mreq) begin
                    map_n   = 1'b0;
                    state_n = exit_req ? S_IDLE : S_REMAP_WAIT;
                end
            end
            S_REMAP_WAIT: begin
                if (fetch) begin
                    map_n   = 1'b1;
                    state_n = S_ACTIVE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Status clear is applied before the new frame-edge triggers are merged in.
        if (drop_cause) begin
            cause_n = '0;
        end else if (clr_stat) begin
            cause_n = cause & ~bus.d[NUM_SRC-1:0];
        end else begin
            cause_n = cause;
        end
        if (frame_edge) begin
            cause_n = cause_n | nmi_src;
        end

        to_flag_n = (to_flag && !(clr_stat && bus.d[7])) || timeout_hit;
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            if (MAGIC_ON_START) begin
                state      <= S_CHECK;
                magic_mode <= 1'b1;
                magic_map  <= 1'b1;
            end else begin
                state      <= S_IDLE;
                magic_mode <= 1'b0;
                magic_map  <= 1'b0;
            end
            n_nmi     <= 1'b1;
            cause     <= '0;
            to_flag   <= 1'b0;
            timer     <= '0;
            chk_seen  <= 1'b0;
            chk_match <= 1'b0;
            exit_req  <= 1'b0;
        end else begin
            state      <= state_n;
            magic_mode <= mode_n;
            magic_map  <= map_n;
            n_nmi      <= n_nmi_n;
            cause      <= cause_n;
            to_flag    <= to_flag_n;
            timer      <= timer_n;
            chk_seen   <= chk_seen_n;
            chk_match  <= chk_match_n;
            exit_req   <= exit_req_n;
        end
    end

    // Config register file, write strobes and read-enable
    always_comb begin
        stb_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            stb_hit[i] = (idx == 8'(i));
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            cfg_q        <= CFG_RESET[NUM_REGS*8-1:8];
            wr_prev      <= 1'b0;
            cfg_wr_stb   <= '0;
            d_out_active <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (cfg_wr && (idx == 8'(i))) begin
                    cfg_q[i*8 +: 8] <= bus.d;
                end
            end
            wr_prev      <= cfg_wr;
            cfg_wr_stb   <= (cfg_wr && !wr_prev && idx_ok) ? stb_hit : '0;
            d_out_active <= cfg_rd;
        end
    end

    // Read mux follows the current index; d_out_active qualifies it.
    always_comb begin
        status                = '0;
        status[NUM_SRC-1:0]   = cause;
        status[7]             = to_flag;
        d_out                 = 8'h00;
        if (idx == 8'd0) begin
            d_out = status;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                d_out = cfg_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_magic_ctrl.sv
// Bench for magic_ctrl: cycle vectors from a table plus hand-written
// sequences for timeout, signature mismatch and asynchronous reset.
module tb_magic_ctrl;

    localparam int NSRC  = 4;
    localparam int NREGS = 16;
    localparam logic [NREGS*8-1:0] CFG_RST = 128'h0000_0000_0000_0000_0000_0000_1100_00FF;

    logic               clk28 = 1'b0;
    logic               rst;
    logic               n_int, n_int_next;
    logic [NSRC-1:0]    nmi_src;
    logic               n_nmi, magic_mode, magic_map;
    logic [NREGS*8-1:0] cfg;
    logic [NREGS-1:0]   cfg_wr_stb;
    logic [7:0]         d_out;
    logic               d_out_active;

    cpu_bus bus ();

    magic_ctrl #(
        .NUM_SRC        (NSRC),
        .NUM_REGS       (NREGS),
        .CFG_RESET      (CFG_RST),
        .MAGIC_ON_START (1'b1),
        .TIMEOUT        (16)
    ) dut (
        .clk28        (clk28),
        .rst          (rst),
        .bus          (bus),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .nmi_src      (nmi_src),
        .n_nmi        (n_nmi),
        .magic_mode   (magic_mode),
        .magic_map    (magic_map),
        .cfg          (cfg),
        .cfg_wr_stb   (cfg_wr_stb),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    always #5 clk28 = ~clk28;

    typedef struct {
        bit          mreq, ioreq, m1, rd, wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [3:0]  src;
        bit          edge_;
        bit          e_nnmi, e_mode, e_map, e_act;
        logic [15:0] e_stb;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit mreq, bit ioreq, bit m1, bit rd, bit wr,
                                logic [15:0] a, logic [7:0] d, logic [3:0] src, bit edge_,
                                bit nn, bit mo, bit mp, bit ac, logic [15:0] stb, logic [7:0] dout);
        vec_t v;
        v.mreq = mreq; v.ioreq = ioreq; v.m1 = m1; v.rd = rd; v.wr = wr;
        v.a = a; v.d = d; v.src = src; v.edge_ = edge_;
        v.e_nnmi = nn; v.e_mode = mo; v.e_map = mp; v.e_act = ac;
        v.e_stb = stb; v.e_dout = dout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit mreq, input bit ioreq, input bit m1, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] d, input logic [3:0] src, input bit edge_);
        bus.mreq = mreq; bus.ioreq = ioreq; bus.m1 = m1; bus.rd = rd; bus.wr = wr;
        bus.a = a; bus.d = d;
        nmi_src    = src;
        n_int      = 1'b1;
        n_int_next = edge_ ? 1'b0 : 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk28);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREGS*8-1:0] exp_cfg;
        int cnt;
        exp_cfg      = CFG_RST;
        exp_cfg[7:0] = 8'h00;

        // Table: one bus cycle per entry, expectations after the clock edge
        //              mrq io m1 rd wr  a        d      src  edge  nnmi mode map act stb       dout
        vt.push_back(mk(1, 0, 1, 1, 0, 16'h0000, 8'hEB, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // signature capture
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // -> ACTIVE
        vt.push_back(mk(0, 1, 0, 0, 1, 16'h03FF, 8'h5A, 4'h0, 0,   1, 1, 1, 0, 16'h0008, 8'h00)); // write idx3, strobe
        vt.push_back(mk(0, 1, 0, 0, 1, 16'h03FF, 8'h5A, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // held write, no strobe
        vt.push_back(mk(0, 1, 0, 0, 1, 16'h03FF, 8'h5A, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00));
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00));
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h03FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h5A)); // read idx3
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h03FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h5A));
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h40FF, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // out-of-range read
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h00)); // status = 0
        vt.push_back(mk(1, 0, 0, 1, 0, 16'hF008, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // remap read
        vt.push_back(mk(1, 0, 0, 1, 0, 16'hF008, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // mreq still high
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 1, 0, 0, 16'h0000, 8'h00)); // unmapped
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h03FF, 8'h00, 4'h0, 0,   1, 1, 0, 0, 16'h0000, 8'h00)); // port hidden when unmapped
        vt.push_back(mk(1, 0, 1, 1, 0, 16'h1234, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // remap on M1
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00));
        vt.push_back(mk(1, 0, 0, 1, 0, 16'hF000, 8'h00, 4'h0, 0,   1, 0, 1, 0, 16'h0000, 8'h00)); // exit read
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 0, 0, 0, 16'h0000, 8'h00)); // -> IDLE
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h4, 1,   0, 1, 0, 0, 16'h0000, 8'h00)); // trigger NMI
        vt.push_back(mk(1, 0, 1, 1, 0, 16'h0066, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // vector fetch
        vt.push_back(mk(1, 0, 1, 1, 0, 16'h0066, 8'hEB, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // signature
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h0, 0,   1, 1, 1, 0, 16'h0000, 8'h00)); // -> ACTIVE
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h04)); // cause = 4
        vt.push_back(mk(0, 1, 0, 0, 1, 16'h00FF, 8'h04, 4'h0, 0,   1, 1, 1, 0, 16'h0001, 8'h00)); // clear cause
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h00));
        vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h3, 1,   1, 1, 1, 0, 16'h0000, 8'h00)); // trigger outside IDLE
        vt.push_back(mk(0, 1, 0, 0, 1, 16'h00FF, 8'h03, 4'h1, 1,   1, 1, 1, 0, 16'h0001, 8'h00)); // clear + edge
        vt.push_back(mk(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0,   1, 1, 1, 1, 16'h0000, 8'h01)); // new bit survives

        // Reset state
        rst = 1'b1;
        idle();
        repeat (3) cyc();
        chk("reset n_nmi", n_nmi, 1'b1);
        chk("reset magic_mode", magic_mode, 1'b1);
        chk("reset magic_map", magic_map, 1'b1);
        chk("reset cfg", cfg, exp_cfg);
        chk("reset cfg_wr_stb", cfg_wr_stb, '0);
        chk("reset d_out_active", d_out_active, 1'b0);
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].mreq, vt[i].ioreq, vt[i].m1, vt[i].rd, vt[i].wr,
                  vt[i].a, vt[i].d, vt[i].src, vt[i].edge_);
            cyc();
            chk($sformatf("v%0d n_nmi", i), n_nmi, vt[i].e_nnmi);
            chk($sformatf("v%0d magic_mode", i), magic_mode, vt[i].e_mode);
            chk($sformatf("v%0d magic_map", i), magic_map, vt[i].e_map);
            chk($sformatf("v%0d d_out_active", i), d_out_active, vt[i].e_act);
            chk($sformatf("v%0d cfg_wr_stb", i), cfg_wr_stb, vt[i].e_stb);
            if (vt[i].e_act) chk($sformatf("v%0d d_out", i), d_out, vt[i].e_dout);
        end
        chk("cfg byte3", cfg[31:24], 8'h5A);

        // Timeout: exit to IDLE, trigger, let NMI_PEND expire
        drive(1, 0, 0, 1, 0, 16'hF000, 8'h00, 4'h0, 0); cyc();
        idle(); cyc();
        chk("exit mode", magic_mode, 1'b0);
        chk("exit map", magic_map, 1'b0);
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h2, 1); cyc();
        chk("pend n_nmi", n_nmi, 1'b0);
        idle();
        cnt = 0;
        while (n_nmi == 1'b0 && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("timeout cycles", cnt, 16);
        chk("timeout mode", magic_mode, 1'b0);

        // Re-enter to reach the config port and inspect the sticky flag
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h2, 1); cyc();
        drive(1, 0, 1, 1, 0, 16'h0066, 8'hEB, 4'h0, 0); cyc();
        chk("reentry map", magic_map, 1'b1);
        drive(0, 1, 0, 0, 1, 16'h00FF, 8'h0F, 4'h0, 0); cyc();
        drive(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0); cyc();
        chk("timeout flag act", d_out_active, 1'b1);
        chk("timeout flag status", d_out, 8'h80);
        drive(0, 1, 0, 0, 1, 16'h00FF, 8'h80, 4'h0, 0); cyc();
        drive(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0); cyc();
        chk("flag cleared status", d_out, 8'h00);

        // Signature mismatch drops the session and the cause
        drive(1, 0, 1, 1, 0, 16'h0066, 8'h00, 4'h0, 0); cyc();
        idle(); cyc();
        chk("mismatch map", magic_map, 1'b0);
        chk("mismatch mode", magic_mode, 1'b0);
        chk("mismatch n_nmi", n_nmi, 1'b1);
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h8, 1); cyc();
        chk("src3 n_nmi", n_nmi, 1'b0);
        drive(1, 0, 1, 1, 0, 16'h0066, 8'h00, 4'h0, 0); cyc();
        drive(0, 1, 0, 1, 0, 16'h00FF, 8'h00, 4'h0, 0); cyc();
        chk("cause after mismatch", d_out, 8'h08);

        // Asynchronous reset while NMI is pending
        drive(1, 0, 1, 1, 0, 16'h0066, 8'h00, 4'h0, 0); cyc();
        idle(); cyc();
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'h1, 1); cyc();
        chk("pre-rst n_nmi", n_nmi, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("async rst n_nmi", n_nmi, 1'b1);
        chk("async rst cfg", cfg, exp_cfg);
        chk("async rst mode", magic_mode, 1'b1);
        chk("async rst map", magic_map, 1'b1);
        cyc();
        rst = 1'b0;

        // Boot straight into CHECK, wrong first opcode
        drive(1, 0, 1, 1, 0, 16'h0000, 8'h00, 4'h0, 0); cyc();
        chk("boot check map", magic_map, 1'b1);
        idle(); cyc();
        chk("boot mismatch map", magic_map, 1'b0);
        chk("boot mismatch mode", magic_mode, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/magic_ctrl.md
Name: magic_ctrl

Overview:
- Parametrised successor to the magic/NMI controller.
- Arbitrates NUM_SRC NMI trigger sources and latches which sources fired (cause register).
- Maps the magic ROM through an explicit state machine: signature check, exit and remap-on-next-fetch, plus an NMI-acknowledge timeout.
- Exposes a generic NUM_REGS-byte config register file with full readback through the magic config I/O port. Sits between the CPU bus and the memory/peripheral mapping logic.

Parameters:
- NUM_SRC, 4: NMI trigger sources, 1..7.
- NUM_REGS, 16: config register indices, 2..256. Index 0 is status/cause.
- CFG_RESET, all zero, NUM_REGS*8 bits: reset value of register i is CFG_RESET[i*8+:8]. Byte 0 is ignored.
- ENTRY_ADDR, 16'h0066: NMI vector fetch address.
- EXIT_ADDR, 16'hF000: read here unmaps and leaves magic mode.
- REMAP_ADDR, 16'hF008: read here unmaps, then remaps on the next M1.
- SIGNATURE, 8'hEB: required first opcode of the magic ROM.
- CONFIG_PORT, 8'hFF: low I/O address byte of the config port.
- MAGIC_ON_START, 1: boot into the CHECK state.
- TIMEOUT, 4095: clk28 cycles allowed in NMI_PEND. 0 disables the timeout.

Ports:
- clk28, in, 1: system clock.
- rst, in, 1: reset; asynchronous, active-high.
- bus, cpu_bus, -: uses mreq, ioreq, m1, rd, wr, a[15:0], d[7:0].
- n_int, in, 1: current INT level.
- n_int_next, in, 1: next-cycle INT level. Frame edge = n_int==1 && n_int_next==0.
- nmi_src, in, NUM_SRC: level trigger requests (magic button, pause, ...).
- n_nmi, out, 1: NMI to CPU, active-low.
- magic_mode, out, 1: magic session active.
- magic_map, out, 1: magic ROM/RAM mapped.
- cfg, out, NUM_REGS*8: flat config register contents. Byte 0 reads as zero.
- cfg_wr_stb, out, NUM_REGS: one-cycle pulse on the first write cycle to an index.
- d_out, out, 8: read data.
- d_out_active, out, 1: d_out drives the bus.

Behaviour:
- States: IDLE, NMI_PEND, CHECK, ACTIVE, UNMAP_WAIT, REMAP_WAIT.
- Reset values:
  - MAGIC_ON_START=1: state CHECK, magic_mode=1, magic_map=1.
  - MAGIC_ON_START=0: state IDLE, both 0.
  - Always: n_nmi=1, cause=0, timeout flag=0, cfg=CFG_RESET, cfg_wr_stb=0, d_out_active=0.
- Cause latching: on every frame edge, cause |= nmi_src, in any state.
- IDLE -> NMI_PEND: at a frame edge with |nmi_src. Registered: n_nmi=0, magic_mode=1.
- NMI_PEND:
  - On m1 && mreq && a==ENTRY_ADDR: n_nmi=1, magic_map=1, go to CHECK.
  - Timer counts clk28 cycles from entry. When it reaches TIMEOUT: n_nmi=1, magic_mode=0, status bit7=1 (sticky), go to IDLE.
- CHECK:
  - On the first m1 && mreq && rd cycle, capture match = (d==SIGNATURE).
  - On the first subsequent cycle without that condition: match -> ACTIVE; mismatch -> IDLE with magic_map=0, magic_mode=0, cause=0.
- ACTIVE:
  - mreq && rd && a==EXIT_ADDR: magic_mode=0 in the same registered cycle; go to UNMAP_WAIT (exit).
  - mreq && rd && a==REMAP_ADDR: go to UNMAP_WAIT (remap).
- UNMAP_WAIT: on the first !mreq cycle, magic_map=0. Exit -> IDLE; remap -> REMAP_WAIT.
- REMAP_WAIT: on m1 && mreq, magic_map=1 and go to ACTIVE. No signature check.
- Config access: config_cs = magic_map && ioreq && a[7:0]==CONFIG_PORT; index = a[15:8].
- Config writes, applied every clk28 cycle while config_cs && wr:
  - index 1..NUM_REGS-1: register[index] = d.
  - index 0: cause &= ~d[NUM_SRC-1:0]; bit7 cleared if d[7]=1.
  - cfg_wr_stb[index] pulses only on the rising edge of (config_cs && wr).
  - Out-of-range index: writes ignored, no strobe.
- Config reads:
  - d_out_active is registered: it is 1 the cycle after config_cs && rd && index<NUM_REGS, and stays 1 while that holds.
  - d_out for index 0 = {timeout flag, zero pad, cause}.
  - d_out for other indices = the register value.
  - Out-of-range reads: d_out_active=0.
- Simultaneous frame edge + write to index 0: the clear applies first, then the new cause is ORed in. The new cause bit survives.
- New triggers outside IDLE only update cause. They never re-assert n_nmi.
- Async rst in any state restores all reset values immediately.

Test Plan:
- MAGIC_ON_START=1, first M1 fetch d=8'hEB -> ACTIVE, map=1. Repeat with d=8'h00 -> IDLE, map=0, mode=0.
- nmi_src=4'b0100 at a frame edge in IDLE -> n_nmi=0. Fetch 0x0066 -> n_nmi=1, map=1. Read index 0 -> d_out=8'h04. Write index 0 with 8'h04 -> cause=0.
- NMI_PEND with no fetch for TIMEOUT=16 cycles -> n_nmi=1 on cycle 16, mode=0, index 0 reads 8'h80.
- In ACTIVE, read 0xF008, mreq drops -> map=0. Next M1 at 0x1234 -> map=1, state ACTIVE. Read 0xF000, mreq drops -> map=0, mode=0.
- Write 8'h5A to port 0x03FF for 3 cycles -> cfg byte3=8'h5A, cfg_wr_stb[3] high for exactly 1 cycle. Read 0x03FF -> d_out=8'h5A with d_out_active=1. Read 0x40FF with NUM_REGS=16 -> d_out_active=0.
- Assert rst in NMI_PEND -> n_nmi=1 at once and cfg=CFG_RESET.
